// File: rtl/muldiv_unit_if.sv
// Interface between decode/control and the iterative multiply/divide unit.
// Groups the request, operand, cancel and result signals. Clock and reset are
// plain ports on the unit itself.
//
// Handshake: a request transfers at a rising edge where i_start=1, i_cancel=0
// and the unit is idle (o_busy=0 and no op in flight); i_op/i_op1/i_op2 are
// captured at that edge. While o_busy=1 the unit is not ready and i_start is
// ignored (no queueing). o_done is a one-cycle result-valid pulse with no
// back-pressure; o_hi/o_lo already hold the new result in that cycle.
interface muldiv_unit_if;
    logic        i_start;
    logic [2:0]  i_op;
    logic [31:0] i_op1;
    logic [31:0] i_op2;
    logic        i_cancel;
    logic        o_busy;
    logic        o_done;
    logic        o_div_by_zero;
    logic [31:0] o_hi;
    logic [31:0] o_lo;

    // Driven by decode/control
    modport master (
        output i_start, i_op, i_op1, i_op2, i_cancel,
        input  o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );

    // Driven by the muldiv unit
    modport slave (
        input  i_start, i_op, i_op1, i_op2, i_cancel,
        output o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle on magnitudes;
// the sign fix is folded into the final HI/LO write (no separate FIX state).
// Optional feature macro: MULDIV_FAST_MUL_EN -- MULT/MULTU use a single-cycle
// 64-bit multiplier (busy for one cycle); divide timing is unchanged.
// o_dbg_state exposes the FSM state for checkers.
module muldiv_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    muldiv_unit_if.slave bus,
    output logic [1:0]  o_dbg_state
);

    localparam int ITER = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e      state_q, state_d;

    // Iteration datapath. acc_q holds {partial product} for multiply and
    // {remainder, quotient/dividend shift} for divide.
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opb_q;      // multiplicand magnitude or divisor magnitude
    logic [31:0] op1_q;      // raw rs operand, returned in HI on divide by zero
    logic        neg_main_q; // negate product / quotient
    logic        neg_rem_q;  // negate remainder (dividend was negative)
    logic        div0_q;

    // Architectural results
    logic [31:0] hi_q, lo_q;
    logic        done_q, dbz_q;

    // FSM control strobes
    logic        start_mul, start_div, mt_hi, mt_lo, step, fin_mul, fin_div;

    // Operand magnitude decode at accept time
    logic        op_signed, sign1, sign2;
    logic [31:0] mag1, mag2;

    // One-bit-per-cycle datapath steps
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;

    // Final-write values
    logic [63:0] prod_mag;
    logic [63:0] mul_res;
    logic [31:0] quot_res, rem_res;

    // MULT and DIV are the even codes among the arithmetic ops
    assign op_signed = ~bus.i_op[0];
    assign sign1     = op_signed & bus.i_op1[31];
    assign sign2     = op_signed & bus.i_op2[31];
    assign mag1      = sign1 ? (32'd0 - bus.i_op1) : bus.i_op1;
    assign mag2      = sign2 ? (32'd0 - bus.i_op2) : bus.i_op2;

    // Shift-add: conditionally add the multiplicand to the upper half, then
    // shift the 65-bit {carry, acc} right by one.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_next  = {mul_sum, acc_q[31:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits.
    assign div_shift = {acc_q[63:32], acc_q[31]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};

`ifdef MULDIV_FAST_MUL_EN
    assign prod_mag  = {32'd0, opb_q} * {32'd0, acc_q[31:0]};
`else
    assign prod_mag  = acc_q;
`endif
    assign mul_res   = neg_main_q ? (64'd0 - prod_mag) : prod_mag;
    assign quot_res  = neg_main_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    assign rem_res   = neg_rem_q  ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and control strobes; cancel beats start and completion
    always_comb begin
        state_d   = state_q;
        start_mul = 1'b0;
        start_div = 1'b0;
        mt_hi     = 1'b0;
        mt_lo     = 1'b0;
        step      = 1'b0;
        fin_mul   = 1'b0;
        fin_div   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start && !bus.i_cancel) begin
                    case (bus.i_op)
                        OP_MULT, OP_MULTU: begin
                            start_mul = 1'b1;
                            state_d   = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            start_div = 1'b1;
                            state_d   = S_DIV;
                        end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (bus.i_cancel) begin
                    state_d = S_IDLE;
`ifdef MULDIV_FAST_MUL_EN
                end else begin
                    fin_mul = 1'b1;
                    state_d = S_IDLE;
                end
`else
                end else if (cnt_q == 6'(ITER)) begin
                    fin_mul = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                end
`endif
            end
            S_DIV: begin
                if (bus.i_cancel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 6'(ITER)) begin
                    fin_div = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture at accept and one iteration per busy edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= 6'd0;
            acc_q      <= 64'd0;
            opb_q      <= 32'd0;
            op1_q      <= 32'd0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
        end else if (start_mul) begin
            cnt_q      <= 6'd0;
            acc_q      <= {32'd0, mag2};
            opb_q      <= mag1;
            op1_q      <= bus.i_op1;
            neg_main_q <= sign1 ^ sign2;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
        end else if (start_div) begin
            cnt_q      <= 6'd0;
            acc_q      <= {32'd0, mag1};
            opb_q      <= mag2;
            op1_q      <= bus.i_op1;
            neg_main_q <= sign1 ^ sign2;
            neg_rem_q  <= sign1;
            div0_q     <= (bus.i_op2 == 32'd0);
        end else if (step) begin
            cnt_q      <= cnt_q + 6'd1;
            acc_q      <= (state_q == S_MUL) ? mul_next : div_next;
        end
    end

    // Architectural HI/LO and the completion pulse; HI/LO change only on
    // MTHI/MTLO or the final write, never mid-operation
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= fin_mul | fin_div;
            dbz_q  <= fin_div & div0_q;
            if (mt_hi) begin
                hi_q <= bus.i_op1;
            end
            if (mt_lo) begin
                lo_q <= bus.i_op1;
            end
            if (fin_mul) begin
                hi_q <= mul_res[63:32];
                lo_q <= mul_res[31:0];
            end
            if (fin_div) begin
                if (div0_q) begin
                    hi_q <= op1_q;
                    lo_q <= 32'hFFFF_FFFF;
                end else begin
                    hi_q <= rem_res;
                    lo_q <= quot_res;
                end
            end
        end
    end

    assign bus.o_busy        = (state_q != S_IDLE);
    assign bus.o_done        = done_q;
    assign bus.o_div_by_zero = dbz_q;
    assign bus.o_hi          = hi_q;
    assign bus.o_lo          = lo_q;
    assign o_dbg_state       = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, cancel/reset
// scenarios and randomized ops against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if bus();
    logic [1:0] dbg_state;

    muldiv_unit dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [64:0] exp_q[$];   // {div_by_zero, hi, lo}
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [64:0] mon_e;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: signed/unsigned arithmetic on 64-bit integers
    function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT: begin
                q = sa * sb;
                return {1'b0, 64'(q)};
            end
            OP_MULTU: begin
                p = ua * ub;
                return {1'b0, p};
            end
            OP_DIV: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                p = ua / ub;
                ua = ua % ub;
                return {1'b0, ua[31:0], p[31:0]};
            end
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'd0, bus.o_done}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_hi", bus.o_hi, mon_e[63:32]);
                    check("done_lo", bus.o_lo, mon_e[31:0]);
                    check("done_dbz", {31'd0, bus.o_div_by_zero}, {31'd0, mon_e[64]});
                end
            end else begin
                check("dbz_without_done", {31'd0, bus.o_div_by_zero}, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit cancel_at_done);
        logic [64:0] e;
        logic [31:0] old_hi, old_lo;
        int n;
        @(negedge clk);
        bus.i_cancel = 1'b0;
        bus.i_start  = 1'b1;
        bus.i_op     = op;
        bus.i_op1    = a;
        bus.i_op2    = b;
        @(negedge clk);
        bus.i_start  = 1'b0;
        bus.i_op1    = $urandom;
        bus.i_op2    = $urandom;
        if (op == OP_MTHI || op == OP_MTLO) begin
            if (op == OP_MTHI) m_hi = a;
            else m_lo = a;
            check("mt_busy", {31'd0, bus.o_busy}, 32'd0);
            check("mt_hi", bus.o_hi, m_hi);
            check("mt_lo", bus.o_lo, m_lo);
            return;
        end
        e = ref_model(op, a, b);
        exp_q.push_back(e);
        old_hi = m_hi;
        old_lo = m_lo;
        n = 0;
        while (bus.o_busy && n < 100) begin
            n++;
            check("hold_hi", bus.o_hi, old_hi);
            check("hold_lo", bus.o_lo, old_lo);
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), (op == OP_MULT || op == OP_MULTU) ? 32'(MUL_LAT) : 32'(DIV_LAT));
        check("done_after_busy", {31'd0, bus.o_done}, 32'd1);
        m_hi = e[63:32];
        m_lo = e[31:0];
        if (cancel_at_done) begin
            bus.i_cancel = 1'b1;
            @(negedge clk);
            bus.i_cancel = 1'b0;
            check("cancel_at_done_hi", bus.o_hi, m_hi);
            check("cancel_at_done_lo", bus.o_lo, m_lo);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        logic [2:0] rop;
        bus.i_start  = 1'b0;
        bus.i_op     = 3'd0;
        bus.i_op1    = 32'd0;
        bus.i_op2    = 32'd0;
        bus.i_cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.o_hi, 32'd0);
        check("rst_lo", bus.o_lo, 32'd0);
        check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
        check("rst_done", {31'd0, bus.o_done}, 32'd0);
        check("rst_dbz", {31'd0, bus.o_div_by_zero}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        rst_n = 1'b1;

        // Directed corners
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("t1_hi", bus.o_hi, 32'hFFFF_FFFE);
        check("t1_lo", bus.o_lo, 32'h0000_0001);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        check("t2_hi", bus.o_hi, 32'hFFFF_FFFF);
        check("t2_lo", bus.o_lo, 32'hFFFF_FFEB);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        check("t3a_hi", bus.o_hi, 32'hFFFF_FFFF);
        check("t3a_lo", bus.o_lo, 32'hFFFF_FFFD);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("t3b_hi", bus.o_hi, 32'h0000_0000);
        check("t3b_lo", bus.o_lo, 32'h8000_0000);
        issue(OP_DIVU, 32'h0000_000A, 32'h0000_0000, 1'b0);
        check("t4_hi", bus.o_hi, 32'h0000_000A);
        check("t4_lo", bus.o_lo, 32'hFFFF_FFFF);
        check("t4_dbz", {31'd0, bus.o_div_by_zero}, 32'd1);

        // Cancel mid-divide, with an ignored start while busy
        issue(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = OP_DIVU;
        bus.i_op1   = 32'd64;
        bus.i_op2   = 32'd3;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = OP_MULTU;
        bus.i_op1   = 32'd9;
        bus.i_op2   = 32'd9;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("t5_busy_mid", {31'd0, bus.o_busy}, 32'd1);
        repeat (4) @(negedge clk);
        bus.i_cancel = 1'b1;
        @(negedge clk);
        bus.i_cancel = 1'b0;
        check("t5_busy_after_cancel", {31'd0, bus.o_busy}, 32'd0);
        check("t5_hi", bus.o_hi, 32'h1234_5678);
        check("t5_lo", bus.o_lo, m_lo);
        // Cancel and start together in idle: nothing starts
        bus.i_start  = 1'b1;
        bus.i_cancel = 1'b1;
        bus.i_op     = OP_MULTU;
        @(negedge clk);
        bus.i_start  = 1'b0;
        bus.i_cancel = 1'b0;
        check("t5_cancel_wins_busy", {31'd0, bus.o_busy}, 32'd0);
        d0 = done_seen;
        repeat (40) @(negedge clk);
        check("t5_no_done", 32'(done_seen - d0), 32'd0);

        // Reset in the middle of a MULT
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = OP_MULT;
        bus.i_op1   = 32'h0000_1234;
        bus.i_op2   = 32'hFFFF_0001;
        @(negedge clk);
        bus.i_start = 1'b0;
        exp_q.push_back(ref_model(OP_MULT, 32'h0000_1234, 32'hFFFF_0001));
        repeat (19) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_hi", bus.o_hi, 32'd0);
        check("t6_lo", bus.o_lo, 32'd0);
        check("t6_busy", {31'd0, bus.o_busy}, 32'd0);
        check("t6_done", {31'd0, bus.o_done}, 32'd0);
        check("t6_dbz", {31'd0, bus.o_div_by_zero}, 32'd0);
        exp_q.delete();
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_MTLO, 32'd5, 32'd0, 1'b0);
        check("t6_mtlo", bus.o_lo, 32'd5);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 5));
            issue(rop, rand_operand(), rand_operand(), ($urandom_range(0, 3) == 0));
        end

        // Drain
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
